// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder/subtractor with a three-state controller.
//
// An operation is accepted on the rising edge where the FSM is IDLE and start=1.
// The operands are then added one bit per clock, LSB first, through a single
// full adder. The result appears on sum/cout together with a one-cycle done
// pulse, WIDTH edges after the accepting edge.
//
// Optional feature macro: SERIAL_ADD_CTRL_SUB_EN
//   defined   -> sub=1 at accept computes a-b (SB <= ~b, carry-in 1);
//                in that case cout is the not-borrow flag.
//   undefined -> the sub input is present but ignored (always add).
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only in IDLE
//   a, b   in   operands, captured on the accepting edge
//   sub    in   0 = add, 1 = subtract (see macro above)
//   busy   out  high while in SHIFT or DONE
//   done   out  one-cycle completion pulse
//   sum    out  registered result, held until the next completion
//   cout   out  registered final carry, held until the next completion
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             cq;
  logic [CNT_W-1:0] cnt;

  logic             sub_eff;
  logic             s;
  logic             c;
  logic             last;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  assign sub_eff = sub;
`else
  // Port kept for interface compatibility; its value never reaches the datapath.
  assign sub_eff = sub & 1'b0;
`endif

  // Single full adder shared across all bit positions.
  assign s    = sa[0] ^ sb[0] ^ cq;
  assign c    = (sa[0] & sb[0]) | (cq & (sa[0] ^ sb[0]));
  assign last = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand shift registers, carry flop, bit counter, result regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      cq   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            // Two's-complement subtract: invert b here, carry-in of 1 below.
            sb  <= sub_eff ? ~b : b;
            cq  <= sub_eff;
            cnt <= '0;
          end
        end
        SHIFT: begin
          // Sum bits enter at the top, so after WIDTH shifts SA holds the result.
          sa  <= {s, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cq  <= c;
          cnt <= cnt + 1'b1;
          if (last) begin
            sum  <= {s, sa[WIDTH-1:1]};
            cout <= c;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl -- scoreboard bench for serial_add_ctrl (WIDTH=4).
// Expected results are computed from the operands when an operation is
// accepted and compared when the DUT raises done.
module tb_serial_add_ctrl;

  localparam int W = 4;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
  } exp_t;

  exp_t sbq[$];

  function automatic exp_t model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                 input logic osub, input int acc);
    exp_t         e;
    logic         eff;
    logic [W-1:0] bb;
    logic [W:0]   r;
    eff    = SUB_EN & osub;
    bb     = eff ? ~ob : ob;
    r      = {1'b0, oa} + {1'b0, bb} + (W+1)'(eff);
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.acc  = acc;
    e.a    = oa;
    e.b    = ob;
    e.sub  = osub;
    return e;
  endfunction

  // Output monitor: one line per completed transaction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sbq.pop_front();
        $display("op a=%0d b=%0d sub=%0d -> sum=%0d cout=%0d (cycle %0d)",
                 e.a, e.b, e.sub, sum, cout, cyc);
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("latency", 32'(cyc - e.acc), 32'(W));
        check("busy_with_done", 32'(busy), 32'd1);
      end
    end
  end

  // Accept one operation, scramble the operands while busy, and measure busy length.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub);
    int bc;
    @(negedge clk);
    start = 1'b1; a = oa; b = ob; sub = osub;
    @(posedge clk); #1;
    check("accept_busy", 32'(busy), 32'd1);
    sbq.push_back(model(oa, ob, osub, cyc));
    start = 1'b0; a = ~oa; b = ~ob; sub = ~osub;
    bc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
    check("busy_len", 32'(bc), 32'(W + 1));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    #2;
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(4'd3, 4'd5, 1'b0);
    do_op(4'd15, 4'd1, 1'b0);
    do_op(4'd15, 4'd15, 1'b0);

    // Idle with start low: result registers must hold.
    repeat (3) @(negedge clk);
    check("hold_sum", 32'(sum), 32'd14);
    check("hold_cout", 32'(cout), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    do_op(4'd5, 4'd3, 1'b1);
    do_op(4'd3, 4'd5, 1'b1);

    // Back-to-back with start held high and operands changed while busy.
    begin : b2b
      int acc1;
      @(negedge clk);
      start = 1'b1; a = 4'd3; b = 4'd5; sub = 1'b0;
      @(posedge clk); #1;
      check("b2b_accept1", 32'(busy), 32'd1);
      acc1 = cyc;
      sbq.push_back(model(4'd3, 4'd5, 1'b0, cyc));
      a = 4'd7; b = 4'd9;
      repeat (5) @(posedge clk); #1;
      check("b2b_gap_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("b2b_accept2", 32'(busy), 32'd1);
      check("b2b_spacing", 32'(cyc - acc1), 32'(W + 2));
      sbq.push_back(model(4'd7, 4'd9, 1'b0, cyc));
      start = 1'b0; a = 4'd0; b = 4'd0;
      repeat (W + 2) @(negedge clk);
      check("b2b_idle_after", 32'(busy), 32'd0);
    end

    // Reset mid-operation: aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd9; sub = 1'b0;
    @(posedge clk); #1;
    check("abort_accept", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_op(4'd2, 4'd2, 1'b0);

    // A few random operations.
    for (int i = 0; i < 6; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
